// File: rtl/sc_level_pkg.sv
// -----------------------------------------------------------------------------
// sc_level_pkg
// Shared definitions for the level sequencer slice:
//   - default parameter values for sc_level_sequencer / sc_lives_counter
//   - FSM state encodings (plain localparam constants, legacy-compatible)
//   - the registered status-flag bundle and a helper that builds it
// -----------------------------------------------------------------------------
package sc_level_pkg;

  localparam int DEFAULT_NUM_LEVELS      = 3;
  localparam int DEFAULT_LEVEL_WIDTH     = 3;
  localparam int DEFAULT_PROGRESS_WIDTH  = 5;
  localparam int DEFAULT_PROGRESS_TARGET = 12;
  localparam int DEFAULT_LIVES           = 3;

  // The lives counter is fixed at 3 bits, enough for the legal 1..7 range.
  localparam int LIVES_WIDTH = 3;

  localparam int STATE_WIDTH = 3;
  localparam logic [STATE_WIDTH-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_PLAY       = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_LEVEL_DONE = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_ENDGAME    = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_GAMEOVER   = 3'd4;

  // Single-bit outputs that are registered together with the state.
  typedef struct packed {
    logic startCount;
    logic levelFinished;
    logic finishedGame;
    logic gameOver;
  } statusFlags_t;

  function automatic statusFlags_t makeFlags(
    input logic startCount,
    input logic levelFinished,
    input logic finishedGame,
    input logic gameOver
  );
    statusFlags_t f;
    f.startCount    = startCount;
    f.levelFinished = levelFinished;
    f.finishedGame  = finishedGame;
    f.gameOver      = gameOver;
    return f;
  endfunction

  // Flag values while no game is running: external counter held in clear.
  localparam statusFlags_t FLAGS_IDLE = '{startCount: 1'b1, default: 1'b0};

endpackage

// File: rtl/sc_lives_counter.sv
// -----------------------------------------------------------------------------
// sc_lives_counter
// Remaining-lives register. Load restores the starting value, decrement
// removes one life and saturates at zero (never wraps). Load wins over
// decrement when both are requested.
//
// Ports:
//   SC_LIVES_COUNTER_CLOCK_50      in   system clock, rising edge
//   SC_LIVES_COUNTER_RESET_InLow   in   asynchronous active-low reset (-> LIVES)
//   SC_LIVES_COUNTER_Load_In       in   reload LIVES on the next edge
//   SC_LIVES_COUNTER_Decrement_In  in   remove one life on the next edge
//   SC_LIVES_COUNTER_Count_Out     out  remaining lives (registered)
//   SC_LIVES_COUNTER_Zero_Out      out  high when no lives remain
// -----------------------------------------------------------------------------
module sc_lives_counter
  import sc_level_pkg::*;
#(
  parameter int LIVES = DEFAULT_LIVES
)
(
  input  logic                   SC_LIVES_COUNTER_CLOCK_50,
  input  logic                   SC_LIVES_COUNTER_RESET_InLow,
  input  logic                   SC_LIVES_COUNTER_Load_In,
  input  logic                   SC_LIVES_COUNTER_Decrement_In,
  output logic [LIVES_WIDTH-1:0] SC_LIVES_COUNTER_Count_Out,
  output logic                   SC_LIVES_COUNTER_Zero_Out
);

  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(LIVES);

  logic [LIVES_WIDTH-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge SC_LIVES_COUNTER_CLOCK_50 or negedge SC_LIVES_COUNTER_RESET_InLow) begin
    if (!SC_LIVES_COUNTER_RESET_InLow) begin
      count <= LIVES_INIT;
    end else if (SC_LIVES_COUNTER_Load_In) begin
      count <= LIVES_INIT;
    end else if (SC_LIVES_COUNTER_Decrement_In && (count != '0)) begin
      count <= count - LIVES_WIDTH'(1);
    end
  end

  assign SC_LIVES_COUNTER_Count_Out = count;
  assign SC_LIVES_COUNTER_Zero_Out  = (count == '0);

endmodule

// File: rtl/sc_level_sequencer.sv
// -----------------------------------------------------------------------------
// sc_level_sequencer
// Game level sequencer: a Moore FSM (IDLE, PLAY, LEVEL_DONE, ENDGAME,
// GAMEOVER) that walks the player through NUM_LEVELS levels, tracks lives via
// sc_lives_counter and drives the clear/hold of the external progress counter.
// Every output comes straight from a register, so an output change appears
// one cycle after the input that caused it is sampled.
//
// Ports:
//   SC_LEVEL_SEQUENCER_CLOCK_50             in   system clock, rising edge
//   SC_LEVEL_SEQUENCER_RESET_InLow          in   asynchronous active-low reset
//   SC_LEVEL_SEQUENCER_Start_In             in   start / restart request (level)
//   SC_LEVEL_SEQUENCER_LvlProgressCount_In  in   external progress count
//   SC_LEVEL_SEQUENCER_PlayerHit_In         in   one-cycle life-lost pulse
//   SC_LEVEL_SEQUENCER_CurrentLevel_Out     out  active level, 0 when idle
//   SC_LEVEL_SEQUENCER_StartCount_Out       out  clear/hold external counter
//   SC_LEVEL_SEQUENCER_LevelFinished_Out    out  one-cycle level-complete pulse
//   SC_LEVEL_SEQUENCER_FinishedGame_Out     out  high in ENDGAME
//   SC_LEVEL_SEQUENCER_GameOver_Out         out  high in GAMEOVER
//   SC_LEVEL_SEQUENCER_Lives_Out            out  remaining lives
// -----------------------------------------------------------------------------
module sc_level_sequencer
  import sc_level_pkg::*;
#(
  parameter int NUM_LEVELS      = DEFAULT_NUM_LEVELS,
  parameter int LEVEL_WIDTH     = DEFAULT_LEVEL_WIDTH,
  parameter int PROGRESS_WIDTH  = DEFAULT_PROGRESS_WIDTH,
  parameter int PROGRESS_TARGET = DEFAULT_PROGRESS_TARGET,
  parameter int LIVES           = DEFAULT_LIVES
)
(
  input  logic                      SC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                      SC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                      SC_LEVEL_SEQUENCER_Start_In,
  input  logic [PROGRESS_WIDTH-1:0] SC_LEVEL_SEQUENCER_LvlProgressCount_In,
  input  logic                      SC_LEVEL_SEQUENCER_PlayerHit_In,
  output logic [LEVEL_WIDTH-1:0]    SC_LEVEL_SEQUENCER_CurrentLevel_Out,
  output logic                      SC_LEVEL_SEQUENCER_StartCount_Out,
  output logic                      SC_LEVEL_SEQUENCER_LevelFinished_Out,
  output logic                      SC_LEVEL_SEQUENCER_FinishedGame_Out,
  output logic                      SC_LEVEL_SEQUENCER_GameOver_Out,
  output logic [LIVES_WIDTH-1:0]    SC_LEVEL_SEQUENCER_Lives_Out
);

  localparam logic [LEVEL_WIDTH-1:0]    LEVEL_FIRST = LEVEL_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0]    LEVEL_LAST  = LEVEL_WIDTH'(NUM_LEVELS);
  localparam logic [PROGRESS_WIDTH-1:0] TARGET      = PROGRESS_WIDTH'(PROGRESS_TARGET);

  logic [STATE_WIDTH-1:0] state;
  logic [STATE_WIDTH-1:0] stateNext;
  logic [LEVEL_WIDTH-1:0] level;
  logic [LEVEL_WIDTH-1:0] levelNext;
  statusFlags_t           flags;
  statusFlags_t           flagsNext;

  logic                   livesLoad;
  logic                   livesDecrement;
  logic [LIVES_WIDTH-1:0] lives;
  logic                   livesZero;

  logic targetReached;
  logic lastLife;
  logic lastLevel;

  assign targetReached = (SC_LEVEL_SEQUENCER_LvlProgressCount_In >= TARGET);
  // Zero is included so a corrupted count can never underflow a hit.
  assign lastLife      = (lives == LIVES_WIDTH'(1)) || livesZero;
  // ">=" keeps the level clamped even if the register were ever corrupted.
  assign lastLevel     = (level >= LEVEL_LAST);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    stateNext      = state;
    levelNext      = level;
    flagsNext      = FLAGS_IDLE;
    livesLoad      = 1'b0;
    livesDecrement = 1'b0;

    case (state)
      ST_IDLE: begin
        levelNext = '0;
        if (SC_LEVEL_SEQUENCER_Start_In) begin
          stateNext = ST_PLAY;
          levelNext = LEVEL_FIRST;
          livesLoad = 1'b1;
          flagsNext = makeFlags(1'b0, 1'b0, 1'b0, 1'b0);
        end
      end

      ST_PLAY: begin
        // Start_In is deliberately not looked at while playing.
        flagsNext = makeFlags(1'b0, 1'b0, 1'b0, 1'b0);
        if (targetReached) begin
          // Completion outranks a simultaneous hit: the life is kept.
          stateNext = ST_LEVEL_DONE;
          flagsNext = makeFlags(1'b1, 1'b1, 1'b0, 1'b0);
        end else if (SC_LEVEL_SEQUENCER_PlayerHit_In) begin
          livesDecrement = 1'b1;
          if (lastLife) begin
            stateNext = ST_GAMEOVER;
            flagsNext = makeFlags(1'b1, 1'b0, 1'b0, 1'b1);
          end else begin
            // One-cycle StartCount restarts the level's progress from zero.
            flagsNext = makeFlags(1'b1, 1'b0, 1'b0, 1'b0);
          end
        end
      end

      ST_LEVEL_DONE: begin
        if (lastLevel) begin
          stateNext = ST_ENDGAME;
          levelNext = LEVEL_LAST;
          flagsNext = makeFlags(1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
          stateNext = ST_PLAY;
          levelNext = level + LEVEL_FIRST;
          flagsNext = makeFlags(1'b0, 1'b0, 1'b0, 1'b0);
        end
      end

      ST_ENDGAME: begin
        flagsNext = makeFlags(1'b1, 1'b0, 1'b1, 1'b0);
        if (SC_LEVEL_SEQUENCER_Start_In) begin
          stateNext = ST_IDLE;
          levelNext = '0;
          livesLoad = 1'b1;
          flagsNext = FLAGS_IDLE;
        end
      end

      ST_GAMEOVER: begin
        flagsNext = makeFlags(1'b1, 1'b0, 1'b0, 1'b1);
        if (SC_LEVEL_SEQUENCER_Start_In) begin
          stateNext = ST_IDLE;
          levelNext = '0;
          livesLoad = 1'b1;
          flagsNext = FLAGS_IDLE;
        end
      end

      default: begin
        // Illegal encoding: fall back to a clean IDLE on the next edge.
        stateNext = ST_IDLE;
        levelNext = '0;
        livesLoad = 1'b1;
        flagsNext = FLAGS_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50 or negedge SC_LEVEL_SEQUENCER_RESET_InLow) begin
    if (!SC_LEVEL_SEQUENCER_RESET_InLow) begin
      state <= ST_IDLE;
      level <= '0;
      flags <= FLAGS_IDLE;
    end else begin
      state <= stateNext;
      level <= levelNext;
      flags <= flagsNext;
    end
  end

  sc_lives_counter #(
    .LIVES (LIVES)
  ) u_lives_counter (
    .SC_LIVES_COUNTER_CLOCK_50     (SC_LEVEL_SEQUENCER_CLOCK_50),
    .SC_LIVES_COUNTER_RESET_InLow  (SC_LEVEL_SEQUENCER_RESET_InLow),
    .SC_LIVES_COUNTER_Load_In      (livesLoad),
    .SC_LIVES_COUNTER_Decrement_In (livesDecrement),
    .SC_LIVES_COUNTER_Count_Out    (lives),
    .SC_LIVES_COUNTER_Zero_Out     (livesZero)
  );

  assign SC_LEVEL_SEQUENCER_CurrentLevel_Out  = level;
  assign SC_LEVEL_SEQUENCER_StartCount_Out    = flags.startCount;
  assign SC_LEVEL_SEQUENCER_LevelFinished_Out = flags.levelFinished;
  assign SC_LEVEL_SEQUENCER_FinishedGame_Out  = flags.finishedGame;
  assign SC_LEVEL_SEQUENCER_GameOver_Out      = flags.gameOver;
  assign SC_LEVEL_SEQUENCER_Lives_Out         = lives;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sc_level_sequencer
// Self-checking bench for sc_level_sequencer with default parameters:
// a directed vector table, hand-written hit / async-reset sequences, and a
// randomized run compared against a phase-level game model.
// -----------------------------------------------------------------------------
module tb_sc_level_sequencer;

  localparam int NUM_LEVELS      = 3;
  localparam int LEVEL_WIDTH     = 3;
  localparam int PROGRESS_WIDTH  = 5;
  localparam int PROGRESS_TARGET = 12;
  localparam int LIVES           = 3;

  logic                      clk      = 1'b0;
  logic                      rstN     = 1'b0;
  logic                      start    = 1'b0;
  logic [PROGRESS_WIDTH-1:0] progress = '0;
  logic                      hit      = 1'b0;

  logic [LEVEL_WIDTH-1:0] level;
  logic                   startCount;
  logic                   levelFinished;
  logic                   finishedGame;
  logic                   gameOver;
  logic [2:0]             lives;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  sc_level_sequencer #(
    .NUM_LEVELS      (NUM_LEVELS),
    .LEVEL_WIDTH     (LEVEL_WIDTH),
    .PROGRESS_WIDTH  (PROGRESS_WIDTH),
    .PROGRESS_TARGET (PROGRESS_TARGET),
    .LIVES           (LIVES)
  ) dut (
    .SC_LEVEL_SEQUENCER_CLOCK_50            (clk),
    .SC_LEVEL_SEQUENCER_RESET_InLow         (rstN),
    .SC_LEVEL_SEQUENCER_Start_In            (start),
    .SC_LEVEL_SEQUENCER_LvlProgressCount_In (progress),
    .SC_LEVEL_SEQUENCER_PlayerHit_In        (hit),
    .SC_LEVEL_SEQUENCER_CurrentLevel_Out    (level),
    .SC_LEVEL_SEQUENCER_StartCount_Out      (startCount),
    .SC_LEVEL_SEQUENCER_LevelFinished_Out   (levelFinished),
    .SC_LEVEL_SEQUENCER_FinishedGame_Out    (finishedGame),
    .SC_LEVEL_SEQUENCER_GameOver_Out        (gameOver),
    .SC_LEVEL_SEQUENCER_Lives_Out           (lives)
  );

  // ---------------------------------------------------------------------------
  // Game model: where the player is in the game, plus level and lives counts.
  // ---------------------------------------------------------------------------
  typedef enum {P_IDLE, P_PLAY, P_DONE, P_WON, P_LOST} phase_e;

  phase_e phase    = P_IDLE;
  int     mLevel   = 0;
  int     mLives   = LIVES;
  bit     mRestart = 1'b0;

  function automatic void modelReset();
    phase    = P_IDLE;
    mLevel   = 0;
    mLives   = LIVES;
    mRestart = 1'b0;
  endfunction

  function automatic void modelStep(input bit s, input int prog, input bit h);
    mRestart = 1'b0;
    case (phase)
      P_IDLE: if (s) begin
        phase  = P_PLAY;
        mLevel = 1;
        mLives = LIVES;
      end
      P_PLAY: begin
        if (prog >= PROGRESS_TARGET) begin
          phase = P_DONE;
        end else if (h) begin
          if (mLives <= 1) begin
            mLives = 0;
            phase  = P_LOST;
          end else begin
            mLives   = mLives - 1;
            mRestart = 1'b1;
          end
        end
      end
      P_DONE: begin
        if (mLevel == NUM_LEVELS) phase = P_WON;
        else begin
          mLevel = mLevel + 1;
          phase  = P_PLAY;
        end
      end
      default: if (s) begin
        phase  = P_IDLE;
        mLevel = 0;
        mLives = LIVES;
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutputs(input string tag, input int eLevel, input bit eSc,
                              input bit eLf, input bit eFg, input bit eGo, input int eLives);
    check({tag, ".level"},         int'(level),         eLevel);
    check({tag, ".startCount"},    int'(startCount),    int'(eSc));
    check({tag, ".levelFinished"}, int'(levelFinished), int'(eLf));
    check({tag, ".finishedGame"},  int'(finishedGame),  int'(eFg));
    check({tag, ".gameOver"},      int'(gameOver),      int'(eGo));
    check({tag, ".lives"},         int'(lives),         eLives);
  endtask

  task automatic checkModel(input string tag);
    checkOutputs(tag, mLevel, (phase != P_PLAY) || mRestart, phase == P_DONE,
                 phase == P_WON, phase == P_LOST, mLives);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int prog, input bit h);
    start    = s;
    progress = PROGRESS_WIDTH'(prog);
    hit      = h;
  endtask

  task automatic applyReset();
    drive(1'b0, 0, 1'b0);
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    modelReset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit s;
    int prog;
    bit h;
    int eLevel;
    bit eSc;
    bit eLf;
    bit eFg;
    bit eGo;
    int eLives;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input bit s, input int prog, input bit h, input int eLevel,
                                 input bit eSc, input bit eLf, input bit eFg, input bit eGo,
                                 input int eLives);
    vec_t v;
    v.s = s; v.prog = prog; v.h = h; v.eLevel = eLevel; v.eSc = eSc;
    v.eLf = eLf; v.eFg = eFg; v.eGo = eGo; v.eLives = eLives;
    vecs.push_back(v);
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //      s  prog h   lvl sc lf fg go lives
    addVec(1,  0,  0,  1,  0, 0, 0, 0, 3);  // start -> level 1
    addVec(0,  5,  0,  1,  0, 0, 0, 0, 3);
    addVec(0, 12,  0,  1,  1, 1, 0, 0, 3);  // exact target -> LEVEL_DONE
    addVec(0,  0,  0,  2,  0, 0, 0, 0, 3);
    addVec(0, 13,  0,  2,  1, 1, 0, 0, 3);
    addVec(0,  0,  0,  3,  0, 0, 0, 0, 3);
    addVec(0, 31,  0,  3,  1, 1, 0, 0, 3);  // max progress
    addVec(0,  0,  0,  3,  1, 0, 1, 0, 3);  // ENDGAME, level held
    addVec(0, 12,  1,  3,  1, 0, 1, 0, 3);  // inputs ignored in ENDGAME
    addVec(1,  0,  0,  0,  1, 0, 0, 0, 3);  // back to IDLE
    addVec(0,  0,  0,  0,  1, 0, 0, 0, 3);
    addVec(1, 11,  0,  1,  0, 0, 0, 0, 3);
    addVec(0, 11,  0,  1,  0, 0, 0, 0, 3);  // one below target
    addVec(0,  0,  1,  1,  1, 0, 0, 0, 2);  // hit -> restart pulse
    addVec(0,  0,  0,  1,  0, 0, 0, 0, 2);
    addVec(1,  0,  0,  1,  0, 0, 0, 0, 2);  // start ignored in PLAY
    addVec(0, 12,  1,  1,  1, 1, 0, 0, 2);  // target beats hit
    addVec(0,  0,  0,  2,  0, 0, 0, 0, 2);
    addVec(0,  0,  1,  2,  1, 0, 0, 0, 1);
    addVec(0,  0,  0,  2,  0, 0, 0, 0, 1);
    addVec(0,  0,  1,  2,  1, 0, 0, 1, 0);  // last life -> GAMEOVER
    addVec(0,  0,  1,  2,  1, 0, 0, 1, 0);  // no wrap below 0
    addVec(1,  0,  0,  0,  1, 0, 0, 0, 3);  // restart -> IDLE

    // Reset state before any clock edge after release.
    applyReset();
    checkOutputs("reset", 0, 1, 0, 0, 0, LIVES);

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].prog, vecs[i].h);
      tick();
      checkOutputs($sformatf("vec%0d", i), vecs[i].eLevel, vecs[i].eSc, vecs[i].eLf,
                   vecs[i].eFg, vecs[i].eGo, vecs[i].eLives);
    end

    // Three hits in level 2, each separated by a quiet cycle.
    applyReset();
    drive(1, 0, 0);  tick(); checkOutputs("hits.start", 1, 0, 0, 0, 0, 3);
    drive(0, 12, 0); tick(); checkOutputs("hits.done1", 1, 1, 1, 0, 0, 3);
    drive(0, 0, 0);  tick(); checkOutputs("hits.lvl2", 2, 0, 0, 0, 0, 3);
    drive(0, 0, 1);  tick(); checkOutputs("hits.h1", 2, 1, 0, 0, 0, 2);
    drive(0, 0, 0);  tick(); checkOutputs("hits.h1q", 2, 0, 0, 0, 0, 2);
    drive(0, 0, 1);  tick(); checkOutputs("hits.h2", 2, 1, 0, 0, 0, 1);
    drive(0, 0, 0);  tick(); checkOutputs("hits.h2q", 2, 0, 0, 0, 0, 1);
    drive(0, 0, 1);  tick(); checkOutputs("hits.h3", 2, 1, 0, 0, 1, 0);
    drive(0, 0, 0);  tick(); checkOutputs("hits.over", 2, 1, 0, 0, 1, 0);

    // Async reset mid-level 2 (after a hit), with no clock edge involved.
    applyReset();
    drive(1, 0, 0);  tick();
    drive(0, 12, 0); tick();
    drive(0, 0, 0);  tick();
    drive(0, 5, 1);  tick();
    drive(0, 5, 0);  tick();
    checkOutputs("midlvl", 2, 0, 0, 0, 0, 2);
    #4 rstN = 1'b0;
    #1 checkOutputs("asyncrst", 0, 1, 0, 0, 0, LIVES);
    #3 rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 12, 1);
      tick();
      checkOutputs($sformatf("postrst%0d", i), 0, 1, 0, 0, 0, LIVES);
    end
    drive(1, 0, 0); tick(); checkOutputs("postrst.start", 1, 0, 0, 0, 0, LIVES);

    // Randomized run against the game model, with occasional async resets.
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #3 rstN = 1'b0;
        #2;
        modelReset();
        checkModel($sformatf("rnd%0d.rst", i));
        rstN = 1'b1;
      end else begin
        bit s;
        bit h;
        int prog;
        s    = ($urandom_range(0, 5) == 0);
        h    = ($urandom_range(0, 6) == 0);
        prog = ($urandom_range(0, 7) == 0) ? int'($urandom_range(PROGRESS_TARGET, 31))
                                           : int'($urandom_range(0, PROGRESS_TARGET - 1));
        drive(s, prog, h);
        tick();
        modelStep(s, prog, h);
        checkModel($sformatf("rnd%0d", i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_level_sequencer.md
SC_LEVEL_SEQUENCER -- requirements
Module: sc_level_sequencer

Interface
REQ-001 Parameter NUM_LEVELS, default 3: number of playable levels, legal range 1..7.
REQ-002 Parameter LEVEL_WIDTH, default 3: width of the level index; SHALL be at least clog2(NUM_LEVELS+1).
REQ-003 Parameter PROGRESS_WIDTH, default 5: width of the progress count input.
REQ-004 Parameter PROGRESS_TARGET, default 12: progress count that completes a level; SHALL fit in PROGRESS_WIDTH bits.
REQ-005 Parameter LIVES, default 3: lives granted at game start, legal range 1..7; the lives counter is 3 bits.
REQ-006 SC_LEVEL_SEQUENCER_CLOCK_50  in  1: single system clock; all logic is on its rising edge.
REQ-007 SC_LEVEL_SEQUENCER_RESET_InLow  in  1: asynchronous, active-low reset.
REQ-008 SC_LEVEL_SEQUENCER_Start_In  in  1: start/restart request, level-sampled.
REQ-009 SC_LEVEL_SEQUENCER_LvlProgressCount_In  in  PROGRESS_WIDTH: current progress count from the external counter.
REQ-010 SC_LEVEL_SEQUENCER_PlayerHit_In  in  1: player lost a life this cycle; expected as a one-cycle pulse.
REQ-011 SC_LEVEL_SEQUENCER_CurrentLevel_Out  out  LEVEL_WIDTH: active level; 0 when no game is running.
REQ-012 SC_LEVEL_SEQUENCER_StartCount_Out  out  1: clears and holds the external progress counter while high.
REQ-013 SC_LEVEL_SEQUENCER_LevelFinished_Out  out  1: one-cycle pulse when a level is completed.
REQ-014 SC_LEVEL_SEQUENCER_FinishedGame_Out  out  1: high while in ENDGAME (all levels won).
REQ-015 SC_LEVEL_SEQUENCER_GameOver_Out  out  1: high while in GAMEOVER (lives exhausted).
REQ-016 SC_LEVEL_SEQUENCER_Lives_Out  out  3: remaining lives.

Function
REQ-017 The block SHALL be a Moore FSM with states IDLE, PLAY, LEVEL_DONE, ENDGAME and GAMEOVER; all outputs SHALL be registered, so each output reflects a transition one cycle after the causing input is sampled.
REQ-018 In IDLE, Start_In=1 SHALL go to PLAY with level=1 and lives=LIVES; otherwise the FSM SHALL stay in IDLE. Outputs: StartCount=1, level=0.
REQ-019 In PLAY, StartCount SHALL be 0 except for a restart pulse (REQ-021), and Start_In SHALL be ignored.
REQ-020 In PLAY, progress >= PROGRESS_TARGET (unsigned compare) SHALL go to LEVEL_DONE.
REQ-021 In PLAY, a PlayerHit with no target reached SHALL decrement lives and assert StartCount for exactly 1 cycle; if lives was 1, the FSM SHALL instead go to GAMEOVER with lives=0.
REQ-022 If target-reached and PlayerHit occur in the same cycle, target-reached SHALL win and lives SHALL be unchanged.
REQ-023 LEVEL_DONE SHALL last exactly 1 cycle with LevelFinished=1 and StartCount=1.
REQ-024 From LEVEL_DONE, if level==NUM_LEVELS the FSM SHALL go to ENDGAME with level held; otherwise it SHALL increment level and return to PLAY.
REQ-025 ENDGAME and GAMEOVER SHALL hold StartCount=1; Start_In=1 SHALL return the FSM to IDLE with level=0 and lives=LIVES.
REQ-026 Unused state encodings SHALL recover to IDLE on the next clock edge.
REQ-027 Lives SHALL never wrap below 0; level SHALL never exceed NUM_LEVELS.

Reset
REQ-028 Asserting reset SHALL, asynchronously and at any time (mid-level included), force: state=IDLE, CurrentLevel=0, StartCount=1, LevelFinished=0, FinishedGame=0, GameOver=0, Lives=LIVES.
REQ-029 After reset deassertion, the first state change SHALL occur on the first clock edge with Start_In=1.

Structure
REQ-030 State encodings and default parameter values SHALL be placed in shared package sc_level_pkg.
REQ-031 The lives decrement/saturate logic SHALL be a sub-module, sc_lives_counter, with load, decrement and zero-flag.

Verification
REQ-032 Reset, then Start pulse -> next cycle: level=1, lives=3, StartCount=0.
REQ-033 Progress=12 in level 1 -> 1-cycle LevelFinished with StartCount=1, then level=2, PLAY.
REQ-034 Complete levels 1..3 -> FinishedGame=1, level=3; then Start -> IDLE, level=0.
REQ-035 Three PlayerHit pulses in level 2 -> lives 2, 1, then GameOver=1 with lives=0; each non-final hit gives a 1-cycle StartCount.
REQ-036 PlayerHit with progress=12 in the same cycle -> LEVEL_DONE and lives unchanged.
REQ-037 Reset asserted mid-level 2 without a clock edge -> all outputs take reset values immediately.
